fix_unsigned_accumulator: RTL
=============================

Name: fix_unsigned_accumulator

Overview:
- Downstream stage of the pipelined unsigned fixed-point multiplier in each systolic processing element.
- Consumes the multiplier's product stream (product + ready strobe) and sums K_len consecutive products into one dot-product result.
- Buffers completed results in a 2-entry output FIFO with valid/ready handshake. The multiplier cannot be stalled, so results arriving at a full FIFO are dropped and flagged.

Parameters:
- WIDTH_product, 32, width of incoming product (multiplicand width + multiplier width)
- WIDTH_acc, 40, accumulator/result width; must be >= WIDTH_product
- WIDTH_k, 8, width of k_len; maximum group length 2^WIDTH_k - 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  product valid; driven from the multiplier's ready
- product  in  WIDTH_product  unsigned product
- k_len  in  WIDTH_k  products per group; sampled on first product of a group; 0 treated as 1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- sum  out  WIDTH_acc  FIFO head result
- sat  out  1  FIFO head result was saturated; constant 0 without SATURATE_EN
- busy  out  1  group in progress (state ACCUM)
- drop_err  out  1  sticky; a completed result was lost because the FIFO was full

Behaviour:
- Reset (rst=0, asynchronous):
  - State becomes IDLE; acc, count and k_reg are cleared; FIFO is emptied.
  - Outputs: out_valid=0, sum=0, sat=0, busy=0, drop_err=0.
  - Reset mid-group discards the partial sum.
- Widths: product is zero-extended to WIDTH_acc; the addition is unsigned modulo 2^WIDTH_acc (see Optional Feature).
- States:
  - IDLE:
    - in_valid=0: stay.
    - in_valid=1: k_reg <= max(k_len,1); acc <= product; count <= 1.
    - If k_reg==1, complete immediately (push) and stay IDLE; else go to ACCUM.
  - ACCUM:
    - in_valid=0: hold all state; gaps of any length are allowed.
    - in_valid=1: acc <= acc+product; count++.
    - If count+1==k_reg, push acc+product to the FIFO, clear acc/count, go to IDLE.
    - k_len changes mid-group are ignored.
- Back-to-back groups: the product arriving the cycle after completion starts a new group with zero bubble.
- Latency: the result is visible at out_valid/sum one cycle after the clock edge that accepts the group's last product, provided the FIFO was empty.
- FIFO (depth 2, registered head):
  - Pop when out_valid & out_ready.
  - Push when full and no pop in the same cycle: result discarded, drop_err <= 1 (held until reset), FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no drop.
  - Push and pop in the same cycle with 1 entry: occupancy stays 1, new result becomes head.
  - sum and sat hold stable while out_valid=1 and out_ready=0.
- busy=1 exactly while in ACCUM.

Optional Feature:
- Macro: FIX_ACC_SATURATE_EN
- Defined:
  - A sum exceeding 2^WIDTH_acc-1 clamps to all-ones and remains clamped for the rest of the group.
  - The group's result is stored with sat=1.
- Undefined: addition wraps modulo 2^WIDTH_acc; sat is tied 0.

Decomposition:
- Shared package: state enum (IDLE, ACCUM); FIFO_DEPTH=2 constant; helper computing minimum safe WIDTH_acc = WIDTH_product + WIDTH_k.
- One natural sub-module: acc_result_fifo, a 2-entry synchronous FIFO with {sat,sum} payload, full/empty, same clk/rst.

Test Plan:
- k_len=4; products 1,2,3,4 on consecutive cycles; out_ready=1 -> out_valid one cycle after 4th accept, sum=10, busy falls same edge.
- k_len=3; products 5,_,_,7,_,9 (gaps) -> single result sum=21; busy held high through the gaps.
- k_len=0; products 6,8 -> two results 6 then 8 (treated as k=1); busy never asserted.
- k_len=1; out_ready=0; products 1,2,3 -> FIFO holds 1,2; drop_err=1 after third; raise out_ready -> pops 1 then 2 only.
- WIDTH_acc=WIDTH_product=32; k_len=2; products FFFFFFFF,2 -> without macro sum=1, sat=0; with FIX_ACC_SATURATE_EN sum=FFFFFFFF, sat=1.
- k_len=4; rst pulsed low after 2 products, then 4 products of 3 -> outputs zero during reset; single result sum=12.

Source files
------------

// File: rtl/fix_unsigned_accumulator_pkg.sv
// Shared types and constants for the unsigned fixed-point dot-product accumulator.
package fix_unsigned_accumulator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  localparam int FIFO_DEPTH = 2;

  // Smallest accumulator width that can never overflow for a full-length group.
  function automatic int min_acc_width(input int width_product, input int width_k);
    return width_product + width_k;
  endfunction

endpackage

// File: rtl/fix_unsigned_accumulator_fifo.sv
// Two-entry result FIFO with a registered head; payload is {sat,sum}.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module acc_result_fifo
  import fix_unsigned_accumulator_pkg::*;
#(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] head, tail;
  logic [1:0]   cnt;
  logic         do_pop, do_push;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = head;

  // Head/tail storage and occupancy; the head register drives the output directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fix_unsigned_accumulator.sv
// Sums k_len consecutive products from the multiplier into one result and
// queues results in a 2-entry FIFO. Results arriving at a full FIFO are dropped
// and flagged on drop_err. Optional clamping on overflow: FIX_ACC_SATURATE_EN.
module fix_unsigned_accumulator
  import fix_unsigned_accumulator_pkg::*;
#(
  parameter int WIDTH_product = 32,
  parameter int WIDTH_acc     = 40,
  parameter int WIDTH_k       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH_product-1:0] product,
  input  logic [WIDTH_k-1:0]       k_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH_acc-1:0]     sum,
  output logic                     sat,
  output logic                     busy,
  output logic                     drop_err
);

  acc_state_t           state, state_nxt;
  logic [WIDTH_acc-1:0] acc, acc_nxt;
  logic [WIDTH_k-1:0]   count, count_nxt;
  logic [WIDTH_k-1:0]   k_reg, k_nxt;
  logic [WIDTH_k-1:0]   k_eff;
  logic [WIDTH_k:0]     cnt_inc;
  logic                 last;
  logic [WIDTH_acc-1:0] prod_ext;
  logic [WIDTH_acc-1:0] add_res;
  logic                 add_sat;
  logic                 push;
  logic [WIDTH_acc:0]   push_data;
  logic [WIDTH_acc:0]   head;
  logic                 fifo_empty, fifo_full, pop;

  assign prod_ext = WIDTH_acc'(product);
  assign k_eff    = (k_len == '0) ? WIDTH_k'(1) : k_len;
  assign cnt_inc  = {1'b0, count} + 1'b1;
  assign last     = (cnt_inc == {1'b0, k_reg});

`ifdef FIX_ACC_SATURATE_EN
  logic [WIDTH_acc:0] add_full;
  logic               sat_grp;

  assign add_full = {1'b0, acc} + {1'b0, prod_ext};
  assign add_sat  = sat_grp | add_full[WIDTH_acc];
  assign add_res  = add_sat ? '1 : add_full[WIDTH_acc-1:0];

  // Once a group overflows it stays clamped; the first product can never overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sat_grp <= 1'b0;
    else if (in_valid) sat_grp <= (state == ACCUM && !last) ? add_sat : 1'b0;
  end
`else
  assign add_sat = 1'b0;
  assign add_res = acc + prod_ext;
`endif

  // Group sequencing: next state, datapath updates and the FIFO push.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    k_nxt     = k_reg;
    push      = 1'b0;
    push_data = '0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          k_nxt = k_eff;
          if (k_eff == WIDTH_k'(1)) begin
            push      = 1'b1;
            push_data = {1'b0, prod_ext};
            acc_nxt   = '0;
            count_nxt = '0;
          end else begin
            acc_nxt   = prod_ext;
            count_nxt = WIDTH_k'(1);
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (last) begin
            push      = 1'b1;
            push_data = {add_sat, add_res};
            acc_nxt   = '0;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            acc_nxt   = add_res;
            count_nxt = cnt_inc[WIDTH_k-1:0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      k_reg <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      k_reg <= k_nxt;
    end
  end

  assign pop = out_valid & out_ready;

  // Sticky loss flag: a result pushed into a full FIFO that is not draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           drop_err <= 1'b0;
    else if (push && fifo_full && !pop) drop_err <= 1'b1;
  end

  acc_result_fifo #(.W(WIDTH_acc + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = ~fifo_empty;
  assign sum       = head[WIDTH_acc-1:0];
  assign sat       = head[WIDTH_acc];
  assign busy      = (state == ACCUM);

endmodule
